// File: rtl/fab_ce_divider_bank.sv
// N_CH programmable clock-enable generators on FAB_CLK; CE is combinational from registers, lock/err registered.
// Config handshake stalls (CFG_READY low) per channel while an update is pending; invalid channels never stall.
module fab_ce_divider_bank #(
   parameter  int N_CH       = 4,
   parameter  int DIV_W      = 8,
   parameter  int DEF_DIV    = 3,
   parameter  int LOCK_DELAY = 16,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              FAB_CLK,
   input  logic              FAB_RESET,
   input  logic              CFG_VALID,
   output logic              CFG_READY,
   input  logic [CH_W-1:0]   CFG_CH,
   input  logic [DIV_W-1:0]  CFG_DIV,
   input  logic              CFG_BYPASS,
   output logic              CFG_ERR,
   input  logic              SYNC,
   output logic [N_CH-1:0]   CE,
   output logic [N_CH-1:0]   CH_LOCK,
   output logic              LOCK
);
   localparam int LC_W = $clog2(LOCK_DELAY + 1);

   typedef struct packed {
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] div;
      logic [DIV_W-1:0] pend_div;
      logic             byp;
      logic             pend_byp;
      logic             pend_v;
   } ch_t;

   ch_t             ch [N_CH];
   logic [LC_W-1:0] lock_cnt;
   logic [N_CH-1:0] term;
   logic [N_CH-1:0] pend_vec;
   logic [N_CH-1:0] acc_ch;
   logic            ch_ok;
   logic            cfg_acc;

   always_comb begin
      term     = '0;
      pend_vec = '0;
      for (int i = 0; i < N_CH; i++) begin
         term[i]     = ch[i].byp | (ch[i].cnt == ch[i].div);
         pend_vec[i] = ch[i].pend_v;
      end
   end

   assign ch_ok     = 32'(CFG_CH) < 32'(N_CH);
   assign CFG_READY = ch_ok ? !pend_vec[CFG_CH] : 1'b1;
   assign cfg_acc   = CFG_VALID & CFG_READY;
   assign CE        = term;

   always_comb begin
      acc_ch = '0;
      for (int i = 0; i < N_CH; i++)
         acc_ch[i] = cfg_acc & ch_ok & (CFG_CH == CH_W'(i));
   end

   always_ff @(posedge FAB_CLK) begin
      if (FAB_RESET) begin
         for (int i = 0; i < N_CH; i++) begin
            ch[i].cnt      <= '0;
            ch[i].div      <= DIV_W'(DEF_DIV);
            ch[i].pend_div <= '0;
            ch[i].byp      <= 1'b0;
            ch[i].pend_byp <= 1'b0;
            ch[i].pend_v   <= 1'b0;
         end
         CH_LOCK  <= '0;
         LOCK     <= 1'b0;
         CFG_ERR  <= 1'b0;
         lock_cnt <= '0;
      end else begin
         CFG_ERR <= cfg_acc & !ch_ok;
         if (lock_cnt != LC_W'(LOCK_DELAY))
            lock_cnt <= lock_cnt + LC_W'(1);
         LOCK <= (lock_cnt == LC_W'(LOCK_DELAY)) & (&CH_LOCK);

         for (int i = 0; i < N_CH; i++) begin
            // Bypass always terminates, so cnt stays at zero there too.
            ch[i].cnt <= (SYNC | term[i]) ? '0 : ch[i].cnt + DIV_W'(1);

            // Pending updates land only at a period boundary (or a SYNC realign).
            if (ch[i].pend_v && (term[i] || SYNC)) begin
               ch[i].div    <= ch[i].pend_div;
               ch[i].byp    <= ch[i].pend_byp;
               ch[i].pend_v <= 1'b0;
            end

            if (acc_ch[i]) begin
               ch[i].pend_div <= CFG_DIV;
               ch[i].pend_byp <= CFG_BYPASS;
               ch[i].pend_v   <= 1'b1;
            end

            // A fresh accept wins over a coincident terminal count.
            if (acc_ch[i])
               CH_LOCK[i] <= 1'b0;
            else if (term[i] && !ch[i].pend_v)
               CH_LOCK[i] <= 1'b1;
         end
      end
   end
endmodule
